// File: rtl/ram_data_master_if.sv
// Request/response channel between a load-store unit and ram_data_master.
interface ram_data_master_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  iReqValid;
  logic                  oReqReady;
  logic                  iReqWrite;
  logic [ADDR_WIDTH-1:0] iReqAddr;
  logic [DATA_WIDTH-1:0] iReqWData;
  logic                  oRspValid;
  logic                  iRspReady;
  logic [DATA_WIDTH-1:0] oRspData;
  logic                  oRspError;

  modport master (
    output iReqValid, iReqWrite, iReqAddr, iReqWData, iRspReady,
    input  oReqReady, oRspValid, oRspData, oRspError
  );

  modport slave (
    input  iReqValid, iReqWrite, iReqAddr, iReqWData, iRspReady,
    output oReqReady, oRspValid, oRspData, oRspError
  );
endinterface

// File: rtl/ram_data_master.sv
// Single-outstanding requester for the data RAM; all outputs registered.
// Define WRITE_READBACK_EN to verify each write by reading the same address back (CHECK state).
module ram_data_master #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MEM_SIZE     = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  ram_data_master_if.slave      bus,
  output logic                  oBusy,
  output logic                  memEnable,
  output logic                  oWriteDataEnable,
  output logic [ADDR_WIDTH-1:0] oReadDataAddress,
  output logic [ADDR_WIDTH-1:0] oWriteDataAddress,
  output logic [DATA_WIDTH-1:0] oDataMemIn,
  input  logic [DATA_WIDTH-1:0] iDataMemOut
);
  localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

`ifdef WRITE_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, RSP, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, RSP} state_t;
`endif

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  busy_q,      busy_d;
  logic                  mem_en_q,    mem_en_d;
  logic                  we_q,        we_d;
  logic [ADDR_WIDTH-1:0] raddr_q,     raddr_d;
  logic [ADDR_WIDTH-1:0] waddr_q,     waddr_d;
  logic [DATA_WIDTH-1:0] din_q,       din_d;

  logic accept, addr_oob, lat_done;

  assign accept   = (state == IDLE) && bus.iReqValid && req_ready_q;
  assign addr_oob = 32'(bus.iReqAddr) >= MEM_SIZE;
  assign lat_done = (cnt == CW'(READ_LATENCY - 1));

  assign bus.oReqReady     = req_ready_q;
  assign bus.oRspValid     = rsp_valid_q;
  assign bus.oRspData      = rsp_data_q;
  assign bus.oRspError     = rsp_err_q;
  assign oBusy             = busy_q;
  assign memEnable         = mem_en_q;
  assign oWriteDataEnable  = we_q;
  assign oReadDataAddress  = raddr_q;
  assign oWriteDataAddress = waddr_q;
  assign oDataMemIn        = din_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      we_q        <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      din_q       <= '0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      we_q        <= we_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      din_q       <= din_d;
    end
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (addr_oob)           next_state = RSP;
          else if (bus.iReqWrite) next_state = WRITE;
          else                    next_state = READ;
        end
      end
      WRITE: begin
        cnt_d = '0;
`ifdef WRITE_READBACK_EN
        next_state = CHECK;
`else
        next_state = RSP;
`endif
      end
      READ: begin
        if (lat_done) next_state = RSP;
        else          cnt_d = cnt + CW'(1);
      end
`ifdef WRITE_READBACK_EN
      CHECK: begin
        if (lat_done) next_state = RSP;
        else          cnt_d = cnt + CW'(1);
      end
`endif
      RSP: begin
        if (bus.iRspReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output registers double as the command latch: waddr_q/din_q hold the
  // accepted write, raddr_q the accepted read address.
  always_comb begin
    req_ready_d = (next_state == IDLE);
    busy_d      = (next_state != IDLE);
    rsp_valid_d = (next_state == RSP);
    we_d        = (next_state == WRITE);
    mem_en_d    = (next_state == WRITE) || (next_state == READ);
`ifdef WRITE_READBACK_EN
    if (next_state == CHECK) mem_en_d = 1'b1;
`endif
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_oob) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else if (bus.iReqWrite) begin
            waddr_d = bus.iReqAddr;
            din_d   = bus.iReqWData;
          end else begin
            raddr_d = bus.iReqAddr;
          end
        end
      end
      WRITE: begin
`ifdef WRITE_READBACK_EN
        raddr_d = waddr_q;
`else
        rsp_data_d = din_q;
        rsp_err_d  = 1'b0;
`endif
      end
      READ: begin
        if (lat_done) begin
          rsp_data_d = iDataMemOut;
          rsp_err_d  = 1'b0;
        end
      end
`ifdef WRITE_READBACK_EN
      CHECK: begin
        if (lat_done) begin
          rsp_data_d = iDataMemOut;
          rsp_err_d  = (iDataMemOut != din_q);
        end
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram_data_master.sv
// Directed vector bench for ram_data_master with an asynchronous-read RAM model.
module tb_ram_data_master;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ram_data_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();
  ram_data_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) obus ();

  logic       busy, mem_en, we;
  logic [9:0] raddr, waddr;
  logic [7:0] din, rdata;
  logic       o_busy, o_en, o_we;
  logic [9:0] o_raddr, o_waddr;
  logic [7:0] o_din;

  ram_data_master #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MEM_SIZE(1024), .READ_LATENCY(1)) u_dut (
    .Clock(Clock), .Reset(Reset), .bus(bus), .oBusy(busy), .memEnable(mem_en),
    .oWriteDataEnable(we), .oReadDataAddress(raddr), .oWriteDataAddress(waddr),
    .oDataMemIn(din), .iDataMemOut(rdata)
  );

  ram_data_master #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .MEM_SIZE(1000), .READ_LATENCY(1)) u_oor (
    .Clock(Clock), .Reset(Reset), .bus(obus), .oBusy(o_busy), .memEnable(o_en),
    .oWriteDataEnable(o_we), .oReadDataAddress(o_raddr), .oWriteDataAddress(o_waddr),
    .oDataMemIn(o_din), .iDataMemOut(8'hFF)
  );

  // Unwritten locations read back addr[7:0]^0xC3, so 0x3FF reads 0x3C until written.
  logic [7:0] mem [1024];
  bit         written [1024];
  logic       corrupt;
  always @(posedge Clock) if (mem_en && we) begin
    mem[waddr]     <= din;
    written[waddr] <= 1'b1;
  end
  assign rdata = (written[raddr] ? mem[raddr] : (raddr[7:0] ^ 8'hC3)) ^ {7'b0, corrupt};

  logic we_prev = 1'b0;
  int   we_twice = 0;
  always @(negedge Clock) begin
    if (we && we_prev) we_twice <= we_twice + 1;
    we_prev <= we;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus.oReqReady, bus.oRspValid, bus.oRspData, bus.oRspError,
                busy, mem_en, we, raddr, waddr, din});
  endfunction

  typedef struct {
    logic rv, rw; logic [9:0] ra; logic [7:0] rd; logic rr;
    logic rdy, vld; logic [7:0] data; logic err, en, we;
    logic [9:0] raddr, waddr; logic [7:0] din; logic busy;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(logic rv, logic rw, logic [9:0] ra, logic [7:0] rd, logic rr,
                              logic rdy, logic vld, logic [7:0] data, logic err, logic en,
                              logic e_we, logic [9:0] e_ra, logic [9:0] e_wa, logic [7:0] e_din,
                              logic e_busy);
    vec_t v;
    v = '{rv, rw, ra, rd, rr, rdy, vld, data, err, en, e_we, e_ra, e_wa, e_din, e_busy};
    tbl.push_back(v);
  endfunction

`ifdef WRITE_READBACK_EN
  localparam logic [9:0] RA1 = 10'h3FF;
`else
  localparam logic [9:0] RA1 = 10'h000;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       got, en_seen;
    int         lat, idx, ridx, extra;
    logic [9:0] oa [3];
    logic       ow [3];
    logic       oerr [3];
    logic [7:0] odata [3];
    int         olat [3];
    logic       oen [3];

    Reset = 1'b0; corrupt = 1'b0;
    bus.iReqValid = 0; bus.iReqWrite = 0; bus.iReqAddr = '0; bus.iReqWData = '0; bus.iRspReady = 0;
    obus.iReqValid = 0; obus.iReqWrite = 0; obus.iReqAddr = '0; obus.iReqWData = '0; obus.iRspReady = 0;

    // idle/write 0x3FF/read 0x3FF/stalled read 0x055
    add(0,0,10'h000,8'h00,1, 1,0,8'h00,0,0,0,10'h000,10'h000,8'h00,0);
    add(1,1,10'h3FF,8'hA5,1, 0,0,8'h00,0,1,1,10'h000,10'h3FF,8'hA5,1);
`ifdef WRITE_READBACK_EN
    add(0,0,10'h000,8'h00,1, 0,0,8'h00,0,1,0,10'h3FF,10'h3FF,8'hA5,1);
`endif
    add(0,0,10'h000,8'h00,1, 0,1,8'hA5,0,0,0,RA1,10'h3FF,8'hA5,1);
    add(0,0,10'h000,8'h00,1, 1,0,8'hA5,0,0,0,RA1,10'h3FF,8'hA5,0);
    add(1,0,10'h3FF,8'h00,1, 0,0,8'hA5,0,1,0,10'h3FF,10'h3FF,8'hA5,1);
    add(0,0,10'h000,8'h00,1, 0,1,8'hA5,0,0,0,10'h3FF,10'h3FF,8'hA5,1);
    add(0,0,10'h000,8'h00,1, 1,0,8'hA5,0,0,0,10'h3FF,10'h3FF,8'hA5,0);
    add(1,0,10'h055,8'h00,0, 0,0,8'hA5,0,1,0,10'h055,10'h3FF,8'hA5,1);
    for (int s = 0; s < 10; s++)
      add(1,1,10'h010,8'h77,0, 0,1,8'h96,0,0,0,10'h055,10'h3FF,8'hA5,1);
    add(0,0,10'h000,8'h00,1, 1,0,8'h96,0,0,0,10'h055,10'h3FF,8'hA5,0);
    add(0,0,10'h000,8'h00,1, 1,0,8'h96,0,0,0,10'h055,10'h3FF,8'hA5,0);

    repeat (2) @(negedge Clock);
    chk("reset_outputs", all_out(), 64'h0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("ready_after_reset", 64'(bus.oReqReady), 64'h1);

    foreach (tbl[i]) begin
      @(negedge Clock);
      bus.iReqValid = tbl[i].rv; bus.iReqWrite = tbl[i].rw; bus.iReqAddr = tbl[i].ra;
      bus.iReqWData = tbl[i].rd; bus.iRspReady = tbl[i].rr;
      @(posedge Clock); #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.oReqReady), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_rsp_valid", i), 64'(bus.oRspValid), 64'(tbl[i].vld));
      chk($sformatf("v%0d_rsp_data", i), 64'(bus.oRspData), 64'(tbl[i].data));
      chk($sformatf("v%0d_rsp_error", i), 64'(bus.oRspError), 64'(tbl[i].err));
      chk($sformatf("v%0d_mem_enable", i), 64'(mem_en), 64'(tbl[i].en));
      chk($sformatf("v%0d_write_enable", i), 64'(we), 64'(tbl[i].we));
      chk($sformatf("v%0d_read_addr", i), 64'(raddr), 64'(tbl[i].raddr));
      chk($sformatf("v%0d_write_addr", i), 64'(waddr), 64'(tbl[i].waddr));
      chk($sformatf("v%0d_mem_in", i), 64'(din), 64'(tbl[i].din));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
    end

    // Back-to-back writes with iReqValid held high
    idx = 0; ridx = 0;
    for (int c = 0; c < 40 && ridx < 4; c++) begin
      @(negedge Clock);
      bus.iReqValid = (idx < 4); bus.iReqWrite = 1'b1; bus.iReqAddr = 10'(idx);
      bus.iReqWData = 8'(8'h10 + idx); bus.iRspReady = 1'b1;
      #1;
      if (bus.iReqValid && bus.oReqReady) begin
        chk($sformatf("b2b%0d_accept_idle", idx), 64'(busy), 64'h0);
        idx++;
      end
      if (bus.oRspValid) begin
        chk($sformatf("b2b%0d_rsp_data", ridx), 64'(bus.oRspData), 64'(8'h10 + ridx));
        chk($sformatf("b2b%0d_rsp_error", ridx), 64'(bus.oRspError), 64'h0);
        ridx++;
      end
    end
    chk("b2b_rsp_count", 64'(ridx), 64'd4);
    extra = 0;
    bus.iReqValid = 1'b0;
    repeat (4) begin
      @(negedge Clock); #1;
      if (bus.oRspValid) extra++;
    end
    chk("b2b_no_duplicate", 64'(extra), 64'h0);
    for (int a = 0; a < 4; a++)
      chk($sformatf("b2b_ram%0d", a), 64'({written[a], mem[a]}), 64'({1'b1, 8'(8'h10 + a)}));

    // MEM_SIZE=1000: two out-of-range commands and the last in-range address
    oa = '{10'h3F0, 10'h3E8, 10'h3E7};
    ow = '{1'b0, 1'b1, 1'b0};
    oerr = '{1'b1, 1'b1, 1'b0};
    odata = '{8'h00, 8'h00, 8'hFF};
    olat = '{1, 1, 2};
    oen = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      obus.iReqValid = 1'b1; obus.iReqWrite = ow[k]; obus.iReqAddr = oa[k];
      obus.iReqWData = 8'h5C; obus.iRspReady = 1'b0;
      got = 1'b0; en_seen = 1'b0; lat = 0;
      for (int c = 1; c <= 6 && !got; c++) begin
        @(posedge Clock); #1;
        obus.iReqValid = 1'b0;
        if (o_en) en_seen = 1'b1;
        if (obus.oRspValid) begin got = 1'b1; lat = c; end
      end
      chk($sformatf("oor%0d_latency", k), 64'(lat), 64'(olat[k]));
      chk($sformatf("oor%0d_error", k), 64'(obus.oRspError), 64'(oerr[k]));
      chk($sformatf("oor%0d_data", k), 64'(obus.oRspData), 64'(odata[k]));
      chk($sformatf("oor%0d_mem_enable_seen", k), 64'(en_seen), 64'(oen[k]));
      chk($sformatf("oor%0d_ready_in_rsp", k), 64'(obus.oReqReady), 64'h0);
      @(negedge Clock);
      obus.iRspReady = 1'b1;
      @(posedge Clock); #1;
      chk($sformatf("oor%0d_rsp_done", k), 64'(obus.oRspValid), 64'h0);
    end

    // Reset while a read of 0x055 is in flight
    @(negedge Clock);
    bus.iReqValid = 1'b1; bus.iReqWrite = 1'b0; bus.iReqAddr = 10'h055; bus.iRspReady = 1'b1;
    @(posedge Clock); #1;
    chk("rst_mid_in_read", 64'(mem_en), 64'h1);
    bus.iReqValid = 1'b0;
    #2 Reset = 1'b0;
    #1 chk("rst_mid_outputs", all_out(), 64'h0);
    @(negedge Clock);
    Reset = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock); #1;
      if (c == 0) chk("rst_mid_ready", 64'(bus.oReqReady), 64'h1);
      if (bus.oRspValid) got = 1'b1;
    end
    chk("rst_mid_no_response", 64'(got), 64'h0);

`ifdef WRITE_READBACK_EN
    @(negedge Clock);
    corrupt = 1'b1;
    bus.iReqValid = 1'b1; bus.iReqWrite = 1'b1; bus.iReqAddr = 10'h010;
    bus.iReqWData = 8'h22; bus.iRspReady = 1'b1;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge Clock); #1;
      bus.iReqValid = 1'b0;
      if (bus.oRspValid) begin got = 1'b1; lat = c; end
    end
    chk("readback_latency", 64'(lat), 64'd3);
    chk("readback_error", 64'(bus.oRspError), 64'h1);
    chk("readback_data", 64'(bus.oRspData), 64'h23);
    @(negedge Clock);
    corrupt = 1'b0;
    repeat (2) @(negedge Clock);
`endif

    chk("write_enable_single_cycle", 64'(we_twice), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
